// File: rtl/arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-input class arbiter.
package arbiter_pkg;

    localparam int NUM_FIFOS = 4;
    localparam int SEL_W     = 2;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    // One-hot read strobe for the selected FIFO index.
    function automatic logic [NUM_FIFOS-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_FIFOS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_grant_4.sv
// Combinational grant picker: lowest index in priority mode, otherwise the
// first requester at or above rr_ptr (wrapping).
module rr_grant_4
    import arbiter_pkg::*;
(
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [SEL_W-1:0]     rr_ptr,
    input  logic                 prio_mode,
    output logic [SEL_W-1:0]     grant_idx,
    output logic                 grant_v
);

    logic [SEL_W-1:0] idx;

    // Scan from the far end toward the preferred start so the nearest match wins.
    always_comb begin
        grant_idx = '0;
        grant_v   = 1'b0;
        idx       = '0;
        if (prio_mode == MODE_PRIO) begin
            for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_idx = SEL_W'(i);
                    grant_v   = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
                idx = rr_ptr + SEL_W'(k);
                if (req[idx]) begin
                    grant_idx = idx;
                    grant_v   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arbiter_4x1.sv
// Drains four per-class FIFOs into one next-stage FIFO. Grant is combinational,
// the popped word is captured two cycles after the pop and strobed downstream.
module arbiter_4x1
    import arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           prio_mode,
    input  logic [NUM_FIFOS-1:0]           fifo_empty,
    input  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data,
    input  logic                           dest_almost_full,
    input  logic                           dest_full,
    output logic [NUM_FIFOS-1:0]           pop,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic                           valid_out,
    output logic [SEL_W-1:0]               class_out,
    output logic                           idle,
    output logic                           overflow_err
);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 sel_v_q, sel_v_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic [SEL_W-1:0]     class_out_q, class_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 overflow_q, overflow_d;

    logic                 stall;
    logic                 any_req;
    logic [NUM_FIFOS-1:0] req;
    logic [NUM_FIFOS-1:0] req_ok;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_v;

    assign stall   = dest_almost_full | dest_full;
    assign req     = ~fifo_empty;
    assign any_req = |req;
    // Stall masks requests so no pop is issued in the cycle it rises.
    assign req_ok  = stall ? '0 : req;

    rr_grant_4 u_grant (
        .req       (req_ok),
        .rr_ptr    (rr_ptr_q),
        .prio_mode (prio_mode),
        .grant_idx (grant_idx),
        .grant_v   (grant_v)
    );

    // Gated by reset so a held-in-reset arbiter can never underflow a FIFO.
    assign pop = (reset && grant_v) ? onehot(grant_idx) : '0;

    // Pointer, two pipeline stages and the sticky overflow flag.
    always_comb begin
        rr_ptr_d    = grant_v ? grant_idx + SEL_W'(1) : rr_ptr_q;
        sel_d       = grant_idx;
        sel_v_d     = grant_v;
        valid_out_d = sel_v_q;
        data_out_d  = data_out_q;
        class_out_d = class_out_q;
        if (sel_v_q) begin
            data_out_d  = fifo_data[int'(sel_q)*DATA_SIZE +: DATA_SIZE];
            class_out_d = sel_q;
        end
        overflow_d  = overflow_q | (valid_out_q & dest_full);
    end

    // Next state: STALL beats ACTIVE beats IDLE; stay ACTIVE while the pipe drains.
    always_comb begin
        state_d = ST_ACTIVE;
        if (any_req && stall) begin
            state_d = ST_STALL;
        end else if (any_req) begin
            state_d = ST_ACTIVE;
        end else if (!sel_v_q && !valid_out_q) begin
            state_d = ST_IDLE;
        end
    end

    // All state registers; reset discards in-flight words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            sel_v_q     <= 1'b0;
            data_out_q  <= '0;
            class_out_q <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            sel_v_q     <= sel_v_d;
            data_out_q  <= data_out_d;
            class_out_q <= class_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign class_out    = class_out_q;
    assign overflow_err = overflow_q;
    assign idle         = (state_q == ST_IDLE);

endmodule
